// File: rtl/scalar_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scalar_alu_pkg
// Description : Shared ALU opcodes, flag bit positions, flag struct and the
//               response-register state encoding for scalar_alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package scalar_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_XORI = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_SLL  = 3'd4;
    localparam logic [2:0] OP_SRL  = 3'd5;
    localparam logic [2:0] OP_MULT = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    // Bit positions inside the 6-bit flag word {c, z, gt, v, n, 0}
    localparam int FLAG_RSVD = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_V    = 2;
    localparam int FLAG_GT   = 3;
    localparam int FLAG_Z    = 4;
    localparam int FLAG_C    = 5;

    typedef struct packed {
        logic c;
        logic z;
        logic gt;
        logic v;
        logic n;
        logic rsvd;
    } alu_flags_t;

    // Response register occupancy
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage
`default_nettype wire

// File: rtl/scalar_alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational scalar ALU: add, xor, sub, slt, sll, srl, mult
//               and nop, with carry/zero/gt/overflow/negative flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import scalar_alu_pkg::*;
#(
    parameter int N = 24
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [2:0]   i_ctrl,
    output logic [N-1:0] o_result,
    output alu_flags_t   o_flags
);

    logic [N:0]   w_sum;
    logic [N:0]   w_diff;
    logic [N-1:0] w_prod;
    logic [4:0]   w_shamt;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    // Carry out of A + ~B + 1: set when no borrow occurs
    assign w_diff  = {1'b0, i_a} + {1'b0, ~i_b} + {{N{1'b0}}, 1'b1};
    assign w_prod  = i_a * i_b;
    assign w_shamt = i_b[7:3];

    // Operation select and flag generation; NOP forces everything to zero
    always_comb begin
        o_result = '0;
        o_flags  = '0;
        case (i_ctrl)
            OP_ADD: begin
                o_result  = w_sum[N-1:0];
                o_flags.c = w_sum[N];
                o_flags.v = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
            end
            OP_XORI: o_result = i_a ^ i_b;
            OP_SUB: begin
                o_result   = w_diff[N-1:0];
                o_flags.c  = w_diff[N];
                o_flags.v  = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
                o_flags.gt = ($signed(i_a) > $signed(i_b));
            end
            OP_SLT:  o_result = {{(N-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLL:  o_result = i_a << w_shamt;
            OP_SRL:  o_result = i_a >> w_shamt;
            OP_MULT: o_result = w_prod;
            default: o_result = '0;
        endcase
        if (i_ctrl != OP_NOP) begin
            o_flags.z = (o_result == '0);
            o_flags.n = o_result[N-1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/scalar_alu_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request
//               vector upward from i_ptr, wrapping, and returns a one-hot
//               grant, its encoded index and an any-request flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW-1:0] w_cand;

    // Walk from the farthest candidate back to i_ptr so the closest hit wins
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = i_ptr + IDW'(k);
            if (i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
        o_grant[o_idx] = o_any;
    end

endmodule
`default_nettype wire

// File: rtl/scalar_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : scalar_alu_arbiter
// Description : Shares one scalar ALU among NREQ valid/ready requesters with
//               round-robin arbitration and a registered, ID-tagged response.
//               Optional macro SCALAR_ALU_ARB_PRIORITY0_EN gives requester 0
//               fixed top priority; the rest stay round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module scalar_alu_arbiter
    import scalar_alu_pkg::*;
#(
    parameter  int N    = 24,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_A,
    input  logic [NREQ*N-1:0] req_B,
    input  logic [NREQ*3-1:0] req_ctrl,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [N-1:0]      resp_result,
    output logic [5:0]        resp_flags
);

    out_state_t      r_state;
    out_state_t      w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [N-1:0]    r_result;
    alu_flags_t      r_flags;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_ptr_adv;
    logic            w_can_accept;
    logic            w_accept;
    logic [N-1:0]    w_a;
    logic [N-1:0]    w_b;
    logic [2:0]      w_ctrl;
    logic [N-1:0]    w_alu_res;
    alu_flags_t      w_alu_flags;

`ifdef SCALAR_ALU_ARB_PRIORITY0_EN
    logic [NREQ-1:0] w_rr_req;
    logic [NREQ-1:0] w_rr_grant;
    logic [IDW-1:0]  w_rr_idx;
    logic            w_rr_any;

    // Requester 0 is removed from the rotation and handled ahead of it
    assign w_rr_req = {req_valid[NREQ-1:1], 1'b0};

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .i_req   (w_rr_req),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

    // Fixed priority for requester 0, otherwise the round-robin choice
    always_comb begin
        w_grant = w_rr_grant;
        w_idx   = w_rr_idx;
        w_any   = w_rr_any;
        if (req_valid[0]) begin
            w_grant = {{(NREQ-1){1'b0}}, 1'b1};
            w_idx   = '0;
            w_any   = 1'b1;
        end
    end

    assign w_ptr_adv = w_accept && !req_valid[0];
`else
    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_ptr_adv = w_accept;
`endif

    // Reset gating keeps req_ready low while rst is asserted
    assign w_can_accept = (r_state == ST_EMPTY) || resp_ready;
    assign w_accept     = w_any && w_can_accept && rst;
    assign req_ready    = w_grant & {NREQ{w_can_accept && rst}};

    // Granted requester's operands feed the shared ALU
    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_ctrl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_a    = req_A[i*N +: N];
                w_b    = req_B[i*N +: N];
                w_ctrl = req_ctrl[i*3 +: 3];
            end
        end
    end

    alu #(.N(N)) u_alu (
        .i_a      (w_a),
        .i_b      (w_b),
        .i_ctrl   (w_ctrl),
        .o_result (w_alu_res),
        .o_flags  (w_alu_flags)
    );

    // Output register occupancy: fill on accept, empty on drain with no refill
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && resp_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result/ID capture and round-robin pointer update, both only on accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
            r_flags  <= '0;
            r_id     <= '0;
            r_ptr    <= '0;
        end else begin
            if (w_accept) begin
                r_result <= w_alu_res;
                r_flags  <= w_alu_flags;
                r_id     <= w_idx;
            end
            if (w_ptr_adv) begin
                r_ptr <= w_idx + IDW'(1);
            end
        end
    end

    assign resp_valid  = (r_state == ST_FULL);
    assign resp_id     = r_id;
    assign resp_result = r_result;
    assign resp_flags  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_scalar_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_scalar_alu_arbiter
// Description : Directed self-checking bench for scalar_alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scalar_alu_arbiter;

    localparam int N    = 24;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_A;
    logic [NREQ*N-1:0] req_B;
    logic [NREQ*3-1:0] req_ctrl;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [N-1:0]      resp_result;
    logic [5:0]        resp_flags;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    scalar_alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_A       (req_A),
        .req_B       (req_B),
        .req_ctrl    (req_ctrl),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_flags  (resp_flags)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [N-1:0] a,
                           input logic [N-1:0] b, input logic [2:0] c);
        req_valid[i]       = v;
        req_A[i*N +: N]    = a;
        req_B[i*N +: N]    = b;
        req_ctrl[i*3 +: 3] = c;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int exp_id;

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        req_A      = '0;
        req_B      = '0;
        req_ctrl   = '0;
        resp_ready = 1'b1;

        // Reset state, with a request pending that must not see ready
        set_req(0, 1'b1, 24'd5, 24'd3, 3'd0);
        tick;
        tick;
        check("rst_valid",  resp_valid,  0);
        check("rst_id",     resp_id,     0);
        check("rst_result", resp_result, 0);
        check("rst_flags",  resp_flags,  0);
        check("rst_ready",  req_ready,   0);
        set_req(0, 1'b0, 24'd0, 24'd0, 3'd0);
        tick;
        rst = 1'b1;

        // Single ADD from requester 0
        set_req(0, 1'b1, 24'd5, 24'd3, 3'd0);
        #1;
        check("add_ready", req_ready, 4'b0001);
        tick;
        set_req(0, 1'b0, 24'd0, 24'd0, 3'd0);
        check("add_valid",  resp_valid,  1);
        check("add_id",     resp_id,     0);
        check("add_result", resp_result, 8);
        check("add_flags",  resp_flags,  6'h00);
        tick;
        check("drain_valid", resp_valid, 0);

        // SUB negative then positive from requester 2
        set_req(2, 1'b1, 24'd3, 24'd5, 3'd2);
        tick;
        check("sub1_id",     resp_id,     2);
        check("sub1_result", resp_result, 24'hFFFFFE);
        check("sub1_flags",  resp_flags,  6'h02);
        set_req(2, 1'b1, 24'd9, 24'd4, 3'd2);
        tick;
        check("sub2_result", resp_result, 5);
        check("sub2_flags",  resp_flags,  6'h28);
        set_req(2, 1'b0, 24'd0, 24'd0, 3'd0);

        // XOR from requester 3 brings the pointer back to 0
        set_req(3, 1'b1, 24'hF0F0F0, 24'h0F0F0F, 3'd1);
        tick;
        set_req(3, 1'b0, 24'd0, 24'd0, 3'd0);
        check("xor_id",     resp_id,     3);
        check("xor_result", resp_result, 24'hFFFFFF);
        check("xor_flags",  resp_flags,  6'h02);
        tick;

        // Fairness: all four requesters held valid, consumer always ready
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 24'(i + 1), 24'd100, 3'd0);
        for (int k = 0; k < 8; k++) begin
            tick;
`ifdef SCALAR_ALU_ARB_PRIORITY0_EN
            exp_id = 0;
`else
            exp_id = k % NREQ;
`endif
            check("fair_valid",  resp_valid,  1);
            check("fair_id",     resp_id,     exp_id);
            check("fair_result", resp_result, exp_id + 101);
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 24'd0, 24'd0, 3'd0);
        tick;
        check("fair_drain", resp_valid, 0);

        // Backpressure: SLT result held while consumer stalls
        resp_ready = 1'b0;
        set_req(1, 1'b1, 24'hFFFFFF, 24'd1, 3'd3);
        #1;
        check("bp_ready_empty", req_ready, 4'b0010);
        tick;
        set_req(1, 1'b0, 24'd0, 24'd0, 3'd0);
        set_req(2, 1'b1, 24'd7, 24'd6, 3'd6);
        check("slt_id",     resp_id,     1);
        check("slt_result", resp_result, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready",  req_ready,   0);
            check("bp_valid",  resp_valid,  1);
            check("bp_result", resp_result, 1);
            tick;
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 4'b0100);
        tick;
        set_req(2, 1'b0, 24'd0, 24'd0, 3'd0);
        check("mul_valid",  resp_valid,  1);
        check("mul_id",     resp_id,     2);
        check("mul_result", resp_result, 42);
        tick;
        check("mul_drain", resp_valid, 0);

        // Shift left then NOP, back to back from requester 0
        set_req(0, 1'b1, 24'd1, 24'h10, 3'd4);
        tick;
        check("sll_result", resp_result, 4);
        check("sll_flags",  resp_flags,  6'h00);
        set_req(0, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 3'd7);
        tick;
        set_req(0, 1'b0, 24'd0, 24'd0, 3'd0);
        check("nop_valid",  resp_valid,  1);
        check("nop_result", resp_result, 0);
        check("nop_flags",  resp_flags,  6'h00);
        tick;

        // Reset mid-stream with requester 1 pending
        resp_ready = 1'b0;
        set_req(1, 1'b1, 24'h800000, 24'h800000, 3'd0);
        tick;
        check("ovf_result", resp_result, 0);
        check("ovf_flags",  resp_flags,  6'h34);
        check("ovf_valid",  resp_valid,  1);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_valid",  resp_valid,  0);
        check("mrst_result", resp_result, 0);
        check("mrst_flags",  resp_flags,  0);
        check("mrst_ready",  req_ready,   0);
        set_req(3, 1'b1, 24'd2, 24'd3, 3'd0);
        tick;
        rst        = 1'b1;
        resp_ready = 1'b1;
        #1;
        check("post_rst_ready", req_ready, 4'b0010);
        tick;
        set_req(1, 1'b0, 24'd0, 24'd0, 3'd0);
        check("post_rst_id1", resp_id, 1);
        tick;
        set_req(3, 1'b0, 24'd0, 24'd0, 3'd0);
        check("post_rst_id3",     resp_id,     3);
        check("post_rst_result3", resp_result, 5);
        tick;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
